// File: rtl/rob_nway_if.sv
// rob_nway_if: ROB bus; master = ID/free-list/CDB side driving dispatch and completion, slave = ROB driving rob_cap/retire/flush
interface rob_nway_if #(
  parameter int WIDTH = 2,
  parameter int CDB_WIDTH = 6,
  parameter int PR_BITS = 7,
  parameter int AR_BITS = 5
);
  localparam int CNT_BITS = $clog2(WIDTH + 1);
  logic [CNT_BITS-1:0] id_dispatch_num;
  logic [WIDTH*AR_BITS-1:0] id_dest_ar_idx;
  logic [WIDTH*PR_BITS-1:0] fl_pr, mt_told;
  logic [WIDTH*64-1:0] id_NPC;
  logic [WIDTH-1:0] id_halt;
  logic [CDB_WIDTH-1:0] cdb_broadcast, cdb_exception;
  logic [CDB_WIDTH*PR_BITS-1:0] cdb_pr_tag;
  logic [CNT_BITS-1:0] rob_cap, retire_num;
  logic [WIDTH*PR_BITS-1:0] retire_tag, retire_told;
  logic [WIDTH*AR_BITS-1:0] retire_ar;
  logic [WIDTH*64-1:0] retire_NPC;
  logic retire_halt, flush;
  modport master (
    output id_dispatch_num, id_dest_ar_idx, fl_pr, mt_told, id_NPC, id_halt,
    output cdb_broadcast, cdb_pr_tag, cdb_exception,
    input rob_cap, retire_num, retire_tag, retire_told, retire_ar, retire_NPC, retire_halt, flush
  );
  modport slave (
    input id_dispatch_num, id_dest_ar_idx, fl_pr, mt_told, id_NPC, id_halt,
    input cdb_broadcast, cdb_pr_tag, cdb_exception,
    output rob_cap, retire_num, retire_tag, retire_told, retire_ar, retire_NPC, retire_halt, flush
  );
endinterface

// File: rtl/rob_nway.sv
// rob_nway: N-wide circular reorder buffer; ports clock, reset (sync active-high), bus (rob_nway_if.slave: dispatch/CDB in, rob_cap/retire/halt/flush out)
module rob_nway #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 2,
  parameter int CDB_WIDTH = 6,
  parameter int PR_BITS = 7,
  parameter int AR_BITS = 5
) (
  input logic clock,
  input logic reset,
  rob_nway_if.slave bus
);
  localparam int CNT_BITS = $clog2(WIDTH + 1);
  localparam int IDX = $clog2(DEPTH);
  localparam int CB = $clog2(DEPTH + 1);
  typedef enum logic {RUN, HALTED} state_e;
  state_e state_q, state_d;
  logic [IDX-1:0] head_q, head_d, tail_q, tail_d;
  logic [CB-1:0] count_q, count_d, free;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, exc_q, exc_d, halt_q, halt_d;
  logic [PR_BITS-1:0] tag_q [DEPTH];
  logic [PR_BITS-1:0] told_q [DEPTH];
  logic [AR_BITS-1:0] ar_q [DEPTH];
  logic [63:0] npc_q [DEPTH];
  logic [IDX-1:0] rd_idx [WIDTH];
  logic [IDX-1:0] wr_idx [WIDTH];
  logic [CNT_BITS-1:0] cap, n, ret_n;
  logic ret_halt, ret_exc;
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_slot
    assign rd_idx[i] = head_q + IDX'(i);
    assign wr_idx[i] = tail_q + IDX'(i);
    assign bus.retire_tag[i*PR_BITS +: PR_BITS] = tag_q[rd_idx[i]];
    assign bus.retire_told[i*PR_BITS +: PR_BITS] = told_q[rd_idx[i]];
    assign bus.retire_ar[i*AR_BITS +: AR_BITS] = ar_q[rd_idx[i]];
    assign bus.retire_NPC[i*64 +: 64] = npc_q[rd_idx[i]];
  end
  assign free = CB'(DEPTH) - count_q;
  assign cap = (reset || state_q == HALTED) ? '0 : (free >= CB'(WIDTH) ? CNT_BITS'(WIDTH) : CNT_BITS'(free));
  assign n = ret_exc ? '0 : (bus.id_dispatch_num > cap ? cap : bus.id_dispatch_num);
  assign bus.rob_cap = cap;
  assign bus.retire_num = ret_n;
  assign bus.retire_halt = ret_halt;
  assign bus.flush = ret_exc;
  // retire group: done entries from head, closed by (and including) the first halt or exception
  always_comb begin
    logic stop;
    ret_n = '0;
    ret_halt = 1'b0;
    ret_exc = 1'b0;
    stop = reset || state_q == HALTED;
    for (int k = 0; k < WIDTH; k++) begin
      if (!stop && valid_q[rd_idx[k]] && done_q[rd_idx[k]]) begin
        ret_n = ret_n + CNT_BITS'(1);
        ret_halt = ret_halt | halt_q[rd_idx[k]];
        ret_exc = ret_exc | exc_q[rd_idx[k]];
        stop = halt_q[rd_idx[k]] | exc_q[rd_idx[k]];
      end else begin
        stop = 1'b1;
      end
    end
  end
  // completion, then retire clear, then dispatch write; dispatch wins so a fresh entry is never done
  always_comb begin
    valid_d = valid_q;
    done_d = done_q;
    exc_d = exc_q;
    halt_d = halt_q;
    for (int e = 0; e < DEPTH; e++)
      for (int p = 0; p < CDB_WIDTH; p++)
        if (valid_q[e] && bus.cdb_broadcast[p] && bus.cdb_pr_tag[p*PR_BITS +: PR_BITS] == tag_q[e]) begin
          done_d[e] = 1'b1;
          exc_d[e] = exc_d[e] | bus.cdb_exception[p];
        end
    for (int k = 0; k < WIDTH; k++)
      if (CNT_BITS'(k) < ret_n) valid_d[rd_idx[k]] = 1'b0;
    for (int k = 0; k < WIDTH; k++)
      if (CNT_BITS'(k) < n) begin
        valid_d[wr_idx[k]] = 1'b1;
        done_d[wr_idx[k]] = 1'b0;
        exc_d[wr_idx[k]] = 1'b0;
        halt_d[wr_idx[k]] = bus.id_halt[k];
      end
    head_d = ret_exc ? '0 : head_q + IDX'(ret_n);
    tail_d = ret_exc ? '0 : tail_q + IDX'(n);
    count_d = ret_exc ? '0 : count_q + CB'(n) - CB'(ret_n);
    valid_d = ret_exc ? '0 : valid_d;
    state_d = ret_halt ? HALTED : state_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q <= '0;
      exc_q <= '0;
      halt_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q <= done_d;
      exc_q <= exc_d;
      halt_q <= halt_d;
    end
  end
  always_ff @(posedge clock)
    for (int k = 0; k < WIDTH; k++)
      if (CNT_BITS'(k) < n) begin
        tag_q[wr_idx[k]] <= bus.fl_pr[k*PR_BITS +: PR_BITS];
        told_q[wr_idx[k]] <= bus.mt_told[k*PR_BITS +: PR_BITS];
        ar_q[wr_idx[k]] <= bus.id_dest_ar_idx[k*AR_BITS +: AR_BITS];
        npc_q[wr_idx[k]] <= bus.id_NPC[k*64 +: 64];
      end
endmodule

// File: tb/tb_rob_nway.sv
// tb_rob_nway: directed scoreboard bench for rob_nway; driver queues expected retire groups, negedge monitor pops and compares
module tb_rob_nway;
  typedef struct { int n; int t0; int t1; bit h; bit f; } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  exp_t exp_q[$];
  int q[$];
  always #5 clk = ~clk;
  rob_nway_if bus ();
  rob_nway dut (.clock(clk), .reset(rst), .bus(bus));
  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk)
    if (bus.retire_num != 0 || bus.retire_halt || bus.flush) begin
      if (exp_q.size() == 0) check("unexpected_retire", {61'd0, bus.retire_num, bus.retire_halt}, 64'd0);
      else begin
        exp_t e;
        int t;
        e = exp_q.pop_front();
        check("retire_num", 64'(bus.retire_num), 64'(e.n));
        check("retire_halt", 64'(bus.retire_halt), 64'(e.h));
        check("flush", 64'(bus.flush), 64'(e.f));
        for (int k = 0; k < e.n && k < 2; k++) begin
          t = k == 0 ? e.t0 : e.t1;
          check("retire_tag", 64'(bus.retire_tag[k*7 +: 7]), 64'(t));
          check("retire_told", 64'(bus.retire_told[k*7 +: 7]), 64'(t + 64));
          check("retire_ar", 64'(bus.retire_ar[k*5 +: 5]), 64'(t % 32));
          check("retire_NPC", bus.retire_NPC[k*64 +: 64], 64'h1000 + 64'(t * 4));
        end
      end
    end
  task automatic idle();
    bus.id_dispatch_num = '0;
    bus.id_halt = '0;
    bus.cdb_broadcast = '0;
    bus.cdb_exception = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic push(int n, int t0, int t1, bit h, bit f);
    exp_q.push_back('{n, t0, t1, h, f});
  endtask
  task automatic set_disp(int n, int t0, int t1, bit h0, bit h1);
    bus.id_dispatch_num = 2'(n);
    bus.fl_pr = {7'(t1), 7'(t0)};
    bus.mt_told = {7'(t1 + 64), 7'(t0 + 64)};
    bus.id_dest_ar_idx = {5'(t1), 5'(t0)};
    bus.id_NPC = {64'h1000 + 64'(t1 * 4), 64'h1000 + 64'(t0 * 4)};
    bus.id_halt = {h1, h0};
  endtask
  task automatic set_cdb(int p, int t, bit e);
    bus.cdb_broadcast[p] = 1'b1;
    bus.cdb_pr_tag[p*7 +: 7] = 7'(t);
    bus.cdb_exception[p] = e;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle();
    mid();
    check("reset_rob_cap", 64'(bus.rob_cap), 64'd0);
    check("reset_retire_num", 64'(bus.retire_num), 64'd0);
    check("reset_flush_halt", {62'd0, bus.flush, bus.retire_halt}, 64'd0);
    step();
    rst = 1'b0;
    mid();
    check("post_reset_rob_cap", 64'(bus.rob_cap), 64'd2);
    check("post_reset_retire_num", 64'(bus.retire_num), 64'd0);
  endtask
  task automatic drain(input int tags[$], input int nexp);
    for (int i = 0; i < nexp; i += 2) push(2, tags[i], tags[i+1], 1'b0, 1'b0);
    for (int i = 0; i < tags.size(); i += 6) begin
      for (int p = 0; p < 6 && i + p < tags.size(); p++) set_cdb(p, tags[i+p], 1'b0);
      step();
    end
    repeat (nexp / 2 + 2) step();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    idle();
    bus.fl_pr = '0;
    bus.mt_told = '0;
    bus.id_dest_ar_idx = '0;
    bus.id_NPC = '0;
    bus.cdb_pr_tag = '0;
    do_reset();
    step();
    for (int i = 0; i < 16; i++) begin
      set_disp(2, 2 * i, 2 * i + 1, 1'b0, 1'b0);
      step();
    end
    mid();
    check("full_rob_cap", 64'(bus.rob_cap), 64'd0);
    set_disp(2, 40, 41, 1'b0, 1'b0);
    step();
    mid();
    check("full_rob_cap_hold", 64'(bus.rob_cap), 64'd0);
    q = {};
    for (int i = 0; i < 32; i++) q.push_back(i);
    q.push_back(40);
    q.push_back(41);
    drain(q, 32);
    mid();
    check("drained_rob_cap", 64'(bus.rob_cap), 64'd2);
    set_disp(2, 10, 11, 1'b0, 1'b0);
    step();
    set_cdb(0, 11, 1'b0);
    mid();
    check("young_done_no_retire", 64'(bus.retire_num), 64'd0);
    step();
    push(2, 10, 11, 1'b0, 1'b0);
    set_cdb(0, 10, 1'b0);
    mid();
    check("head_not_done_no_retire", 64'(bus.retire_num), 64'd0);
    step();
    step();
    step();
    do_reset();
    step();
    for (int i = 0; i < 15; i++) begin
      set_disp(2, 2 * i, 2 * i + 1, 1'b0, 1'b0);
      step();
    end
    set_disp(1, 30, 0, 1'b0, 1'b0);
    step();
    mid();
    check("cap_at_31", 64'(bus.rob_cap), 64'd1);
    set_cdb(0, 0, 1'b0);
    step();
    push(1, 0, 0, 1'b0, 1'b0);
    set_disp(2, 50, 51, 1'b0, 1'b0);
    mid();
    check("cap_clip_one", 64'(bus.rob_cap), 64'd1);
    step();
    mid();
    check("count_stays_31", 64'(bus.rob_cap), 64'd1);
    set_disp(2, 52, 53, 1'b0, 1'b0);
    step();
    mid();
    check("wrapped_full_cap", 64'(bus.rob_cap), 64'd0);
    q = {};
    for (int i = 1; i <= 30; i++) q.push_back(i);
    q.push_back(50);
    q.push_back(52);
    drain(q, 32);
    set_disp(2, 20, 21, 1'b0, 1'b0);
    step();
    set_disp(2, 22, 23, 1'b0, 1'b0);
    step();
    set_cdb(0, 20, 1'b0);
    set_cdb(1, 21, 1'b1);
    set_cdb(2, 22, 1'b0);
    set_cdb(3, 23, 1'b0);
    step();
    push(2, 20, 21, 1'b0, 1'b1);
    set_disp(2, 60, 61, 1'b0, 1'b0);
    step();
    mid();
    check("post_flush_rob_cap", 64'(bus.rob_cap), 64'd2);
    check("post_flush_retire", 64'(bus.retire_num), 64'd0);
    set_cdb(0, 22, 1'b0);
    set_cdb(1, 23, 1'b0);
    set_cdb(2, 60, 1'b0);
    set_cdb(3, 61, 1'b0);
    step();
    repeat (3) begin
      mid();
      check("flushed_no_retire", 64'(bus.retire_num), 64'd0);
      step();
    end
    set_disp(2, 30, 31, 1'b1, 1'b0);
    step();
    set_cdb(0, 30, 1'b0);
    set_cdb(1, 31, 1'b0);
    step();
    push(1, 30, 0, 1'b1, 1'b0);
    step();
    repeat (3) begin
      set_disp(2, 40, 41, 1'b0, 1'b0);
      mid();
      check("halted_rob_cap", 64'(bus.rob_cap), 64'd0);
      check("halted_retire_num", 64'(bus.retire_num), 64'd0);
      step();
    end
    do_reset();
    step();
    for (int i = 0; i < 10; i++) begin
      set_disp(2, 2 * i, 2 * i + 1, 1'b0, 1'b0);
      step();
    end
    for (int p = 0; p < 6; p++) set_cdb(p, p, 1'b0);
    step();
    do_reset();
    step();
    repeat (2) begin
      mid();
      check("stale_no_retire", 64'(bus.retire_num), 64'd0);
      step();
    end
    set_disp(2, 0, 1, 1'b0, 1'b0);
    step();
    set_cdb(0, 0, 1'b0);
    set_cdb(1, 1, 1'b0);
    set_cdb(2, 5, 1'b0);
    push(2, 0, 1, 1'b0, 1'b0);
    step();
    repeat (3) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
